// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS link sequencer: state encoding, DVI control
// tokens and channel geometry.
package tmds_pkg;

    localparam int TMDS_CHANNELS = 3;
    localparam int SYM_W         = 10;
    localparam int TMDS_W        = TMDS_CHANNELS * SYM_W;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_SER_RESET = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_CTRL      = 3'd3,
        ST_ACTIVE    = 3'd4
    } state_e;

    // DVI control tokens indexed by {vsync, hsync}
    localparam logic [SYM_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

    function automatic logic [TMDS_W-1:0] ctrl_symbols(input logic [1:0] sync_sel);
        logic [SYM_W-1:0] tok;
        case (sync_sel)
            2'b00:   tok = CTRL_TOKEN_00;
            2'b01:   tok = CTRL_TOKEN_01;
            2'b10:   tok = CTRL_TOKEN_10;
            2'b11:   tok = CTRL_TOKEN_11;
            default: tok = CTRL_TOKEN_00;
        endcase
        return {TMDS_CHANNELS{tok}};
    endfunction

endpackage

// File: rtl/tmds_link_sequencer_if.sv
// Signal bundle between the link sequencer, the TMDS encoders/PLL side and the
// serializer side.
interface tmds_link_sequencer_if;
    import tmds_pkg::*;

    logic              pll_lock;
    logic              restart;
    logic              frame_start;
    logic [TMDS_W-1:0] tmds_video;
    logic              ser_reset;
    logic [TMDS_W-1:0] tmds_internal;
    logic              link_up;
    logic [2:0]        state_o;

    modport master (
        output pll_lock, restart, frame_start, tmds_video,
        input  ser_reset, tmds_internal, link_up, state_o
    );

    modport slave (
        input  pll_lock, restart, frame_start, tmds_video,
        output ser_reset, tmds_internal, link_up, state_o
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop bit synchronizer with asynchronous active-low reset; each bit is
// synchronized independently.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Metastability stage followed by the resolved stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= '0;
            sync_r <= '0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/tmds_link_sequencer.sv
// Power-up / recovery sequencer for the 3-channel TMDS serializer: waits for a
// stable PLL lock, resets and settles the serializers, sends control tokens,
// then forwards encoder video from a frame boundary.
module tmds_link_sequencer
    import tmds_pkg::*;
#(
    parameter int LOCK_STABLE    = 1024,
    parameter int SER_RST_CYCLES = 16,
    parameter int SETTLE_CYCLES  = 16,
    parameter int CTRL_CYCLES    = 64,
    parameter int CNT_W          = 16
) (
    input  logic                  clk_pixel,
    input  logic                  reset_n,
    tmds_link_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] LOCK_TC   = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] SER_TC    = CNT_W'(SER_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CTRL_TC   = CNT_W'(CTRL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              lock_s;
    logic              legal_busy_s;
    state_e            state_r;
    state_e            state_n_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_n_s;
    logic              ser_reset_r;
    logic              ser_reset_n_s;
    logic              link_up_r;
    logic              link_up_n_s;
    logic [TMDS_W-1:0] tmds_r;
    logic [TMDS_W-1:0] tmds_n_s;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk_pixel),
        .rst_n (reset_n),
        .d     (bus.pll_lock),
        .q     (lock_s)
    );

    assign legal_busy_s = (state_r == ST_SER_RESET) || (state_r == ST_SETTLE) ||
                          (state_r == ST_CTRL)      || (state_r == ST_ACTIVE);

    // Next-state and counter logic, with lock-loss / restart aborts overriding
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        case (state_r)
            ST_WAIT_LOCK: begin
                if (!lock_s) begin
                    cnt_n_s = CNT_ZERO;
                end else if (cnt_r == LOCK_TC) begin
                    state_n_s = ST_SER_RESET;
                    cnt_n_s   = CNT_ZERO;
                end else begin
                    cnt_n_s = cnt_r + CNT_ONE;
                end
            end
            ST_SER_RESET: begin
                if (cnt_r == SER_TC) begin
                    state_n_s = ST_SETTLE;
                    cnt_n_s   = CNT_ZERO;
                end else begin
                    cnt_n_s = cnt_r + CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == SETTLE_TC) begin
                    state_n_s = ST_CTRL;
                    cnt_n_s   = CNT_ZERO;
                end else begin
                    cnt_n_s = cnt_r + CNT_ONE;
                end
            end
            ST_CTRL: begin
                // Saturate at the terminal count; frame_start only counts once saturated
                if (cnt_r == CTRL_TC) begin
                    if (bus.frame_start) begin
                        state_n_s = ST_ACTIVE;
                        cnt_n_s   = CNT_ZERO;
                    end else begin
                        cnt_n_s = cnt_r;
                    end
                end else begin
                    cnt_n_s = cnt_r + CNT_ONE;
                end
            end
            ST_ACTIVE: begin
                cnt_n_s = CNT_ZERO;
            end
            default: begin
                state_n_s = ST_WAIT_LOCK;
                cnt_n_s   = CNT_ZERO;
            end
        endcase

        if (legal_busy_s) begin
            if (!lock_s) begin
                state_n_s = ST_WAIT_LOCK;
                cnt_n_s   = CNT_ZERO;
            end else if (bus.restart) begin
                state_n_s = ST_SER_RESET;
                cnt_n_s   = CNT_ZERO;
            end else begin
                state_n_s = state_n_s;
            end
        end else begin
            state_n_s = state_n_s;
        end
    end

    // Outputs are decoded from the next state so they line up with state_o
    always_comb begin
        ser_reset_n_s = (state_n_s == ST_WAIT_LOCK) || (state_n_s == ST_SER_RESET);
        link_up_n_s   = (state_n_s == ST_ACTIVE);
        if (state_n_s == ST_ACTIVE) begin
            tmds_n_s = bus.tmds_video;
        end else begin
            tmds_n_s = ctrl_symbols(2'b00);
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_WAIT_LOCK;
            cnt_r       <= CNT_ZERO;
            ser_reset_r <= 1'b1;
            link_up_r   <= 1'b0;
            tmds_r      <= ctrl_symbols(2'b00);
        end else begin
            state_r     <= state_n_s;
            cnt_r       <= cnt_n_s;
            ser_reset_r <= ser_reset_n_s;
            link_up_r   <= link_up_n_s;
            tmds_r      <= tmds_n_s;
        end
    end

    assign bus.state_o       = state_r;
    assign bus.ser_reset     = ser_reset_r;
    assign bus.link_up       = link_up_r;
    assign bus.tmds_internal = tmds_r;

endmodule

// File: tb/tb_tmds_link_sequencer.sv
// Scoreboard bench for tmds_link_sequencer: the stimulus process queues the
// expected per-cycle outputs, a negedge monitor pops and compares them.
module tb_tmds_link_sequencer;

    logic clk_pixel = 1'b0;
    logic reset_n;

    tmds_link_sequencer_if bus();

    tmds_link_sequencer #(
        .LOCK_STABLE    (8),
        .SER_RST_CYCLES (4),
        .SETTLE_CYCLES  (4),
        .CTRL_CYCLES    (8),
        .CNT_W          (16)
    ) dut (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    always #5 clk_pixel = ~clk_pixel;

    localparam logic [29:0] TOK3 = 30'b110101010011010101001101010100;

    typedef struct {
        int          cyc;
        logic [2:0]  st;
        logic        sr;
        logic        lu;
        logic [29:0] tm;
    } exp_t;

    exp_t q[$];
    int   total    = 0;
    int   bad      = 0;
    int   stim_cyc = 0;
    int   mon_cyc  = 0;

    task automatic tick();
        @(posedge clk_pixel);
        #1;
        stim_cyc++;
    endtask

    task automatic push(input logic [2:0] st, input logic [29:0] vid);
        exp_t e;
        e.cyc = stim_cyc;
        e.st  = st;
        e.sr  = (st == 3'd0) || (st == 3'd1);
        e.lu  = (st == 3'd4);
        e.tm  = (st == 3'd4) ? vid : TOK3;
        q.push_back(e);
    endtask

    task automatic expect_n(input logic [2:0] st, input int n, input logic [29:0] vid);
        for (int i = 0; i < n; i++) begin
            tick();
            push(st, vid);
        end
    endtask

    // Monitor: compare every queued expectation that is due this cycle
    always @(negedge clk_pixel) begin : monitor
        exp_t e;
        mon_cyc++;
        while (q.size() > 0 && q[0].cyc <= mon_cyc) begin
            e = q.pop_front();
            total++;
            if (e.cyc < mon_cyc) begin
                bad++;
                $display("FAIL missed cyc=%0d got nothing at cyc=%0d", e.cyc, mon_cyc);
            end else if ({bus.state_o, bus.ser_reset, bus.link_up, bus.tmds_internal} !==
                         {e.st, e.sr, e.lu, e.tm}) begin
                bad++;
                $display("FAIL out@cyc%0d got state=%0d ser_reset=%0b link_up=%0b tmds=%h want state=%0d ser_reset=%0b link_up=%0b tmds=%h",
                         mon_cyc, bus.state_o, bus.ser_reset, bus.link_up, bus.tmds_internal,
                         e.st, e.sr, e.lu, e.tm);
            end
        end
    end

    initial begin
        reset_n         = 1'b0;
        bus.pll_lock    = 1'b0;
        bus.restart     = 1'b0;
        bus.frame_start = 1'b0;
        bus.tmds_video  = 30'd0;

        // Reset state, then lock bring-up
        tick();
        push(3'd0, 30'd0);
        reset_n      = 1'b1;
        bus.pll_lock = 1'b1;
        expect_n(3'd0, 9, 30'd0);
        expect_n(3'd1, 4, 30'd0);
        expect_n(3'd2, 4, 30'd0);
        expect_n(3'd3, 4, 30'd0);

        // Early frame_start at CTRL count 3 is ignored
        bus.frame_start = 1'b1;
        bus.tmds_video  = 30'h2BADBAD;
        expect_n(3'd3, 1, 30'd0);
        bus.frame_start = 1'b0;
        expect_n(3'd3, 5, 30'd0);

        // Accepted frame_start after saturation
        bus.frame_start = 1'b1;
        bus.tmds_video  = 30'h1234567;
        expect_n(3'd4, 1, 30'h1234567);
        bus.frame_start = 1'b0;
        bus.tmds_video  = 30'h0ABCDEF;
        expect_n(3'd4, 1, 30'h0ABCDEF);
        bus.tmds_video  = 30'h3FF00FF;
        expect_n(3'd4, 1, 30'h3FF00FF);

        // Lock loss in ACTIVE: visible 3 cycles after the pin edge
        bus.pll_lock = 1'b0;
        expect_n(3'd4, 2, 30'h3FF00FF);
        expect_n(3'd0, 1, 30'd0);

        // Relock with a one-cycle glitch at WAIT_LOCK count 5
        bus.pll_lock = 1'b1;
        expect_n(3'd0, 5, 30'd0);
        bus.pll_lock = 1'b0;
        expect_n(3'd0, 1, 30'd0);
        bus.pll_lock = 1'b1;
        expect_n(3'd0, 9, 30'd0);
        expect_n(3'd1, 4, 30'd0);
        expect_n(3'd2, 4, 30'd0);
        expect_n(3'd3, 8, 30'd0);

        // ACTIVE, then restart
        bus.frame_start = 1'b1;
        bus.tmds_video  = 30'h2AAAAAA;
        expect_n(3'd4, 1, 30'h2AAAAAA);
        bus.frame_start = 1'b0;
        bus.tmds_video  = 30'h1555555;
        expect_n(3'd4, 1, 30'h1555555);
        bus.restart = 1'b1;
        expect_n(3'd1, 1, 30'd0);
        bus.restart = 1'b0;
        expect_n(3'd1, 3, 30'd0);
        expect_n(3'd2, 4, 30'd0);
        expect_n(3'd3, 8, 30'd0);

        // ACTIVE, then restart coinciding with synchronized lock loss
        bus.frame_start = 1'b1;
        bus.tmds_video  = 30'h0000001;
        expect_n(3'd4, 1, 30'h0000001);
        bus.frame_start = 1'b0;
        bus.pll_lock    = 1'b0;
        expect_n(3'd4, 2, 30'h0000001);
        bus.restart = 1'b1;
        expect_n(3'd0, 1, 30'd0);
        expect_n(3'd0, 1, 30'd0);
        bus.restart = 1'b0;

        // Bring-up again, then asynchronous reset mid-CTRL
        bus.pll_lock = 1'b1;
        expect_n(3'd0, 9, 30'd0);
        expect_n(3'd1, 4, 30'd0);
        expect_n(3'd2, 4, 30'd0);
        expect_n(3'd3, 3, 30'd0);
        tick();
        #2;
        reset_n = 1'b0;
        push(3'd0, 30'd0);
        tick();
        push(3'd0, 30'd0);
        reset_n = 1'b1;
        expect_n(3'd0, 9, 30'd0);
        expect_n(3'd1, 2, 30'd0);

        repeat (3) @(negedge clk_pixel);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
